// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding and sizing helper for the bit-serial subtractor.
//   Contents: state_e (S_IDLE/S_SHIFT/S_DONE), DEFAULT_WIDTH, cnt_width().
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // One extra bit so the counter can reach WIDTH when WIDTH is a power of two.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus of the serial subtractor.
//   start       host -> block  request, sampled only while idle
//   a, b        host -> block  minuend / subtrahend, captured on accepted start
//   busy        block -> host  high while an operation is in flight (SHIFT and DONE)
//   done        block -> host  one-cycle pulse, result valid
//   diff        block -> host  a - b mod 2^WIDTH, held until the next done
//   borrow_out  block -> host  1 iff a < b, held with diff
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_fs.sv
// serial_subtractor_fs: single-bit subtraction cells used by the serial subtractor.
//   half_subtractor: x_i, y_i -> d_o (difference), b_o (borrow)
//   full_subtractor: x_i, y_i, bin_i -> d_o (difference), bout_o (borrow)
module half_subtractor (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic b_o
);
    assign d_o = x_i ^ y_i;
    assign b_o = ~x_i & y_i;
endmodule

module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    logic d1, b1, b2;

    half_subtractor u_hs0 (.x_i(x_i), .y_i(y_i),   .d_o(d1),  .b_o(b1));
    // Second stage subtracts the incoming borrow from the first-stage difference.
    half_subtractor u_hs1 (.x_i(d1),  .y_i(bin_i), .d_o(d_o), .b_o(b2));

    assign bout_o = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per cycle LSB first, start/done handshake.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset, aborts any operation without a done
//   bus   slave side of serial_subtractor_if (start, a, b -> busy, done, diff, borrow_out)
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, sd_q, diff_q;
    logic [WIDTH-1:0] sd_d;
    logic [CW-1:0]    cnt_q;
    logic             br_q, bo_q, busy_q, done_q;
    logic             fs_d, fs_bo;

    full_subtractor u_fs (
        .x_i   (sa_q[0]),
        .y_i   (sb_q[0]),
        .bin_i (br_q),
        .d_o   (fs_d),
        .bout_o(fs_bo)
    );

    // Result bits enter at the top so the LSB lands at bit 0 after WIDTH shifts.
    assign sd_d = {fs_d, sd_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sd_q  <= sd_d;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    br_q  <= fs_bo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q  <= sd_d;
                        bo_q    <= fs_bo;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor (WIDTH=8 and WIDTH=4)
//   against an arithmetic reference ((a-b) mod 2^W, a<b).
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   last_d = 0;
    int   last_b = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) b8 ();
    serial_subtractor_if #(.WIDTH(4)) b4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input int a, input int b, input bit pulse);
        int n;
        int ed;
        int eb;
        ed = (a - b) & 255;
        eb = (a < b) ? 1 : 0;
        b8.start = 1'b1;
        b8.a = 8'(a);
        b8.b = 8'(b);
        tick();
        b8.start = 1'b0;
        chk("busy_shift", int'(b8.busy), 1);
        n = 0;
        do begin
            n++;
            if (pulse && n == 2) begin
                b8.start = 1'b1;
                b8.a = 8'($urandom);
                b8.b = 8'($urandom);
            end
            if (n == 3) b8.start = 1'b0;
            if (n == 4) begin
                chk("hold_diff", int'(b8.diff), last_d);
                chk("hold_borrow", int'(b8.borrow_out), last_b);
            end
            tick();
        end while (!b8.done && n < 30);
        chk("latency", n, 8);
        chk("diff", int'(b8.diff), ed);
        chk("borrow", int'(b8.borrow_out), eb);
        chk("busy_done", int'(b8.busy), 1);
        last_d = ed;
        last_b = eb;
        tick();
        chk("done_pulse", int'(b8.done), 0);
        chk("busy_idle", int'(b8.busy), 0);
        chk("diff_held", int'(b8.diff), ed);
    endtask

    task automatic op4(input int a, input int b);
        int n;
        b4.start = 1'b1;
        b4.a = 4'(a);
        b4.b = 4'(b);
        tick();
        b4.start = 1'b0;
        n = 0;
        do begin
            n++;
            tick();
        end while (!b4.done && n < 20);
        chk("w4_latency", n, 4);
        chk("w4_diff", int'(b4.diff), (a - b) & 15);
        chk("w4_borrow", int'(b4.borrow_out), (a < b) ? 1 : 0);
        tick();
    endtask

    initial begin
        int qa[4];
        int qb[4];
        int n;
        int seen;
        b8.start = 1'b0; b8.a = '0; b8.b = '0;
        b4.start = 1'b0; b4.a = '0; b4.b = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(b8.busy), 0);
        chk("rst_done", int'(b8.done), 0);
        chk("rst_diff", int'(b8.diff), 0);
        chk("rst_borrow", int'(b8.borrow_out), 0);
        chk("rst_w4_diff", int'(b4.diff), 0);
        tick();

        op8(100, 37, 1'b0);
        op8(5, 10, 1'b0);
        op8(0, 1, 1'b0);
        op8(255, 255, 1'b0);
        op8(200, 3, 1'b1);

        // start held high continuously: one result every WIDTH+2 cycles
        for (int i = 0; i < 4; i++) begin
            qa[i] = int'($urandom_range(255));
            qb[i] = int'($urandom_range(255));
        end
        b8.start = 1'b1;
        b8.a = 8'(qa[0]);
        b8.b = 8'(qb[0]);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                n++;
                tick();
            end while (!b8.done && n < 30);
            chk("b2b_gap", n, (i == 0) ? 9 : 10);
            chk("b2b_diff", int'(b8.diff), (qa[i] - qb[i]) & 255);
            chk("b2b_borrow", int'(b8.borrow_out), (qa[i] < qb[i]) ? 1 : 0);
            last_d = (qa[i] - qb[i]) & 255;
            last_b = (qa[i] < qb[i]) ? 1 : 0;
            if (i < 3) begin
                b8.a = 8'(qa[i + 1]);
                b8.b = 8'(qb[i + 1]);
            end else begin
                b8.start = 1'b0;
            end
        end
        tick();
        tick();
        chk("b2b_idle", int'(b8.busy), 0);

        // reset in the middle of an operation
        b8.start = 1'b1;
        b8.a = 8'd77;
        b8.b = 8'd12;
        tick();
        b8.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", int'(b8.busy), 0);
        chk("abort_diff", int'(b8.diff), 0);
        chk("abort_borrow", int'(b8.borrow_out), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (b8.done) seen++;
            tick();
        end
        chk("abort_no_done", seen, 0);
        last_d = 0;
        last_b = 0;
        op8(77, 12, 1'b0);

        for (int i = 0; i < 20; i++) op8(int'($urandom_range(255)), int'($urandom_range(255)), i[0]);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                op4(x, y);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
